// File: rtl/framebuffer_cmd_sequencer.sv
// Framebuffer command sequencer.
//
// Accepts commit/memset commands from the command decoder and dispatches them to the
// per-target handlers (0 = color, 1 = depth, 2 = stencil). Memset-only targets are
// launched together. Commit targets run one at a time in ascending index order
// because they share a single output stream, which this block multiplexes. A command
// completes (done pulse) only after every involved handler reports applied.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   s_cmd_*                    command input (valid/ready, per-target masks, size)
//   hApply/hApplied            per-handler apply pulse / applied (idle) flag
//   hCmdCommit/hCmdMemset      per-handler flags, non-zero only while hApply is high
//   hCmdSize                   size latched at command accept
//   s_axis_*                   per-handler streams (flattened, target i in slice i)
//   m_axis_*                   merged output stream
//   busy, done                 command in progress / one-cycle completion pulse
//
// Build option:
//   FB_SEQ_MERGE_TLAST_EN      when defined, m_axis_tlast is raised only on the last
//                              beat of the final committed target, so all commits of a
//                              command form one packet. Otherwise each target's tlast
//                              passes through unchanged.
module framebuffer_cmd_sequencer #(
  parameter int unsigned NUM_TARGETS         = 3,
  parameter int unsigned STREAM_WIDTH        = 32,
  parameter int unsigned FB_SIZE_IN_PIXEL_LG = 20
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                s_cmd_valid,
  output logic                                s_cmd_ready,
  input  logic [NUM_TARGETS-1:0]              s_cmd_commit,
  input  logic [NUM_TARGETS-1:0]              s_cmd_memset,
  input  logic [FB_SIZE_IN_PIXEL_LG-1:0]      s_cmd_size,
  output logic [NUM_TARGETS-1:0]              hApply,
  input  logic [NUM_TARGETS-1:0]              hApplied,
  output logic [NUM_TARGETS-1:0]              hCmdCommit,
  output logic [NUM_TARGETS-1:0]              hCmdMemset,
  output logic [FB_SIZE_IN_PIXEL_LG-1:0]      hCmdSize,
  input  logic [NUM_TARGETS-1:0]              s_axis_tvalid,
  input  logic [NUM_TARGETS-1:0]              s_axis_tlast,
  input  logic [NUM_TARGETS*STREAM_WIDTH-1:0] s_axis_tdata,
  output logic [NUM_TARGETS-1:0]              s_axis_tready,
  output logic                                m_axis_tvalid,
  output logic                                m_axis_tlast,
  output logic [STREAM_WIDTH-1:0]             m_axis_tdata,
  input  logic                                m_axis_tready,
  output logic                                busy,
  output logic                                done
);

  localparam int unsigned SelW = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StParStart,
    StSelect,
    StCApply,
    StCGuard,
    StCWait,
    StFinalWait,
    StDone
  } state_e;

  state_e                         state_q, state_d;
  logic [NUM_TARGETS-1:0]         commit_mask_q, commit_mask_d;
  logic [NUM_TARGETS-1:0]         memset_mask_q, memset_mask_d;
  logic [NUM_TARGETS-1:0]         rem_q, rem_d;  // commit targets not yet dispatched
  logic [SelW-1:0]                sel_q, sel_d;
  logic [FB_SIZE_IN_PIXEL_LG-1:0] size_q, size_d;
  logic [NUM_TARGETS-1:0]         apply_q, apply_d;
  logic [NUM_TARGETS-1:0]         cmd_commit_q, cmd_commit_d;
  logic [NUM_TARGETS-1:0]         cmd_memset_q, cmd_memset_d;
  logic                           ready_q, ready_d;
  logic                           busy_q, busy_d;
  logic                           done_q, done_d;

  logic [NUM_TARGETS-1:0]         par_mask;
  logic                           found;
  logic [SelW-1:0]                low_idx;

  assign par_mask = memset_mask_q & ~commit_mask_q;

  // Lowest remaining commit target.
  always_comb begin
    found   = 1'b0;
    low_idx = '0;
    for (int unsigned i = 0; i < NUM_TARGETS; i++) begin
      if (!found && rem_q[i]) begin
        found   = 1'b1;
        low_idx = SelW'(i);
      end
    end
  end

  // Next state. Outputs are registered: each one is computed for the state being
  // entered, so hApply and the flags line up with PAR_START / C_APPLY for one cycle.
  always_comb begin
    state_d       = state_q;
    commit_mask_d = commit_mask_q;
    memset_mask_d = memset_mask_q;
    rem_d         = rem_q;
    sel_d         = sel_q;
    size_d        = size_q;
    apply_d       = '0;
    cmd_commit_d  = '0;
    cmd_memset_d  = '0;

    unique case (state_q)
      StIdle: begin
        if (s_cmd_valid) begin
          commit_mask_d = s_cmd_commit;
          memset_mask_d = s_cmd_memset;
          rem_d         = s_cmd_commit;
          size_d        = s_cmd_size;
          if ((s_cmd_commit | s_cmd_memset) == '0) begin
            state_d = StDone;
          end else begin
            state_d      = StParStart;
            apply_d      = s_cmd_memset & ~s_cmd_commit;
            cmd_memset_d = s_cmd_memset & ~s_cmd_commit;
          end
        end
      end
      StParStart: state_d = StSelect;
      StSelect: begin
        if (found) begin
          sel_d                 = low_idx;
          rem_d[low_idx]        = 1'b0;
          state_d               = StCApply;
          apply_d[low_idx]      = 1'b1;
          cmd_commit_d[low_idx] = 1'b1;
          cmd_memset_d[low_idx] = memset_mask_q[low_idx];
        end else begin
          state_d = StFinalWait;
        end
      end
      StCApply: state_d = StCGuard;
      // Gives the handler's registered applied flag a cycle to fall.
      StCGuard: state_d = StCWait;
      StCWait: begin
        if (hApplied[sel_q]) state_d = StSelect;
      end
      StFinalWait: begin
        if ((hApplied & par_mask) == par_mask) state_d = StDone;
      end
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  assign ready_d = (state_d == StIdle);
  assign busy_d  = (state_d != StIdle);
  assign done_d  = (state_d == StDone);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      commit_mask_q <= '0;
      memset_mask_q <= '0;
      rem_q         <= '0;
      sel_q         <= '0;
      size_q        <= '0;
      apply_q       <= '0;
      cmd_commit_q  <= '0;
      cmd_memset_q  <= '0;
      ready_q       <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      commit_mask_q <= commit_mask_d;
      memset_mask_q <= memset_mask_d;
      rem_q         <= rem_d;
      sel_q         <= sel_d;
      size_q        <= size_d;
      apply_q       <= apply_d;
      cmd_commit_q  <= cmd_commit_d;
      cmd_memset_q  <= cmd_memset_d;
      ready_q       <= ready_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign s_cmd_ready = ready_q;
  assign hApply      = apply_q;
  assign hCmdCommit  = cmd_commit_q;
  assign hCmdMemset  = cmd_memset_q;
  assign hCmdSize    = size_q;
  assign busy        = busy_q;
  assign done        = done_q;

  // Combinational stream mux: no added latency between the selected handler and output.
  always_comb begin
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tdata  = '0;
    s_axis_tready = '0;
    if (state_q == StCWait) begin
      m_axis_tvalid        = s_axis_tvalid[sel_q];
      m_axis_tdata         = s_axis_tdata[int'(sel_q)*STREAM_WIDTH +: STREAM_WIDTH];
`ifdef FB_SEQ_MERGE_TLAST_EN
      // Only the final committed target closes the packet.
      m_axis_tlast         = s_axis_tlast[sel_q] && (rem_q == '0);
`else
      m_axis_tlast         = s_axis_tlast[sel_q];
`endif
      s_axis_tready[sel_q] = m_axis_tready;
    end
  end

endmodule

// File: tb/tb_framebuffer_cmd_sequencer.sv
module tb_framebuffer_cmd_sequencer;

  localparam int NT = 3;
  localparam int SW = 32;
  localparam int SZ = 20;

  logic              clk = 1'b0;
  logic              reset;
  logic              s_cmd_valid;
  logic              s_cmd_ready;
  logic [NT-1:0]     s_cmd_commit;
  logic [NT-1:0]     s_cmd_memset;
  logic [SZ-1:0]     s_cmd_size;
  logic [NT-1:0]     hApply;
  logic [NT-1:0]     hCmdCommit;
  logic [NT-1:0]     hCmdMemset;
  logic [SZ-1:0]     hCmdSize;
  logic [NT*SW-1:0]  s_axis_tdata;
  logic [NT-1:0]     s_axis_tready;
  logic              m_axis_tvalid;
  logic              m_axis_tlast;
  logic [SW-1:0]     m_axis_tdata;
  logic              m_axis_tready = 1'b1;
  logic              busy;
  logic              done;

  // Handler models.
  logic [NT-1:0]     h_applied;
  logic [NT-1:0]     h_tvalid;
  logic [NT-1:0]     h_tlast;
  logic [SW-1:0]     h_tdata [NT];
  int                h_phase [NT];
  int                h_beat  [NT];
  int                h_delay [NT];
  logic              hres;

  // Stimulus-owned command context.
  int                nb [NT];
  int                cmd_id;
  int                cmd_seq;
  int unsigned       max_delay;
  int                rdy_mode;
  logic [NT-1:0]     exp_commit;
  logic [NT-1:0]     exp_memset;
  logic [SZ-1:0]     exp_size;

  typedef struct {
    logic [SW-1:0] data;
    logic          last;
  } beat_t;
  beat_t exp_q[$];

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign s_axis_tdata = {h_tdata[2], h_tdata[1], h_tdata[0]};

  framebuffer_cmd_sequencer #(
    .NUM_TARGETS        (NT),
    .STREAM_WIDTH       (SW),
    .FB_SIZE_IN_PIXEL_LG(SZ)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .s_cmd_valid  (s_cmd_valid),
    .s_cmd_ready  (s_cmd_ready),
    .s_cmd_commit (s_cmd_commit),
    .s_cmd_memset (s_cmd_memset),
    .s_cmd_size   (s_cmd_size),
    .hApply       (hApply),
    .hApplied     (h_applied),
    .hCmdCommit   (hCmdCommit),
    .hCmdMemset   (hCmdMemset),
    .hCmdSize     (hCmdSize),
    .s_axis_tvalid(h_tvalid),
    .s_axis_tlast (h_tlast),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tready(s_axis_tready),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tready(m_axis_tready),
    .busy         (busy),
    .done         (done)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [SW-1:0] beat_word(input int id, input int t, input int b);
    return {id[15:0], t[3:0], b[11:0]};
  endfunction

  // Handler: applied drops the cycle after apply, a commit streams nb[i] beats,
  // then applied returns after a random delay.
  always @(posedge clk) begin
    for (int i = 0; i < NT; i++) begin
      if (hres) begin
        h_applied[i] <= 1'b1;
        h_tvalid[i]  <= 1'b0;
        h_tlast[i]   <= 1'b0;
        h_tdata[i]   <= '0;
        h_phase[i]   <= 0;
        h_beat[i]    <= 0;
        h_delay[i]   <= 0;
      end else if (hApply[i]) begin
        h_applied[i] <= 1'b0;
        if (hCmdCommit[i]) begin
          h_phase[i]  <= 1;
          h_beat[i]   <= 0;
          h_tvalid[i] <= 1'b1;
          h_tdata[i]  <= beat_word(cmd_id, i, 0);
          h_tlast[i]  <= (nb[i] == 1);
        end else begin
          h_phase[i] <= 2;
          h_delay[i] <= $urandom_range(max_delay, 0);
        end
      end else if (h_phase[i] == 1) begin
        if (h_tvalid[i] && s_axis_tready[i]) begin
          if (h_beat[i] == nb[i] - 1) begin
            h_tvalid[i] <= 1'b0;
            h_tlast[i]  <= 1'b0;
            h_phase[i]  <= 2;
            h_delay[i]  <= $urandom_range(max_delay, 0);
          end else begin
            h_beat[i]  <= h_beat[i] + 1;
            h_tdata[i] <= beat_word(cmd_id, i, h_beat[i] + 1);
            h_tlast[i] <= (h_beat[i] + 1 == nb[i] - 1);
          end
        end
      end else if (h_phase[i] == 2) begin
        if (h_delay[i] == 0) begin
          h_applied[i] <= 1'b1;
          h_phase[i]   <= 0;
        end else begin
          h_delay[i] <= h_delay[i] - 1;
        end
      end
    end
  end

  // Output backpressure: 0 always ready, 1 toggle, 2 random.
  always @(posedge clk) begin
    case (rdy_mode)
      0:       m_axis_tready <= 1'b1;
      1:       m_axis_tready <= ~m_axis_tready;
      default: m_axis_tready <= 1'($urandom_range(1, 0));
    endcase
  end

  // Monitor: apply scoreboard, stream scoreboard and completion checks.
  int            apply_cnt [NT];
  logic [NT-1:0] prev_apply;
  int            seen_seq = 0;
  int            last_commit;
  int            done_cnt = 0;
  beat_t         got;
  logic [NT-1:0] allowed;
  logic          ok;

  always @(negedge clk) begin
    if (cmd_seq != seen_seq) begin
      seen_seq = cmd_seq;
      for (int i = 0; i < NT; i++) apply_cnt[i] = 0;
      last_commit = -1;
    end
    if (!reset && !hres) begin
      for (int i = 0; i < NT; i++) begin
        if (hApply[i]) begin
          if (prev_apply[i]) check("apply_pulse_len", 64'(1), 64'(0));
          apply_cnt[i]++;
          check("apply_commit_flag", 64'(hCmdCommit[i]), 64'(exp_commit[i]));
          check("apply_memset_flag", 64'(hCmdMemset[i]), 64'(exp_memset[i]));
          check("apply_size", 64'(hCmdSize), 64'(exp_size));
          if (exp_commit[i]) begin
            ok = 1'b1;
            for (int j = 0; j < NT; j++) begin
              if (j < i && exp_commit[j] && !(apply_cnt[j] == 1 && h_applied[j])) ok = 1'b0;
              if (j > i && exp_commit[j] && apply_cnt[j] != 0) ok = 1'b0;
            end
            check("commit_order", 64'(ok), 64'(1));
            last_commit = i;
          end
        end else begin
          check("flags_outside_apply", 64'({hCmdCommit[i], hCmdMemset[i]}), 64'(0));
        end
      end
      allowed = (last_commit >= 0) ? NT'(1 << last_commit) : '0;
      check("tready_leak", 64'(s_axis_tready & ~allowed), 64'(0));
      if (last_commit < 0) check("tvalid_without_commit", 64'(m_axis_tvalid), 64'(0));
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          check("beat_unexpected", {32'h0, m_axis_tdata}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          got = exp_q.pop_front();
          check("beat_data", 64'(m_axis_tdata), 64'(got.data));
          check("beat_last", 64'(m_axis_tlast), 64'(got.last));
        end
      end
      if (done) begin
        for (int i = 0; i < NT; i++)
          check("apply_count", 64'(apply_cnt[i]), 64'(exp_commit[i] | exp_memset[i]));
        check("done_all_applied", 64'(h_applied), 64'({NT{1'b1}}));
        check("done_stream_drained", 64'(exp_q.size()), 64'(0));
        done_cnt++;
      end
      prev_apply = hApply;
    end else begin
      prev_apply = '0;
    end
  end

  // Issue one command; the reference stream is the commit targets' beats in
  // ascending index order.
  task automatic issue_cmd(input logic [NT-1:0] c, input logic [NT-1:0] m,
                           input int minb, input int maxb);
    int    w;
    int    lastc;
    beat_t e;
    @(negedge clk);
    w = 0;
    while (!s_cmd_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("cmd_ready_before_issue", 64'(s_cmd_ready), 64'(1));
    cmd_id++;
    exp_commit = c;
    exp_memset = m;
    exp_size   = SZ'($urandom);
    lastc      = -1;
    for (int i = 0; i < NT; i++) begin
      nb[i] = $urandom_range(maxb, minb);
      if (c[i]) lastc = i;
    end
    for (int i = 0; i < NT; i++) begin
      if (c[i]) begin
        for (int b = 0; b < nb[i]; b++) begin
          e.data = beat_word(cmd_id, i, b);
`ifdef FB_SEQ_MERGE_TLAST_EN
          e.last = (b == nb[i] - 1) && (i == lastc);
`else
          e.last = (b == nb[i] - 1);
`endif
          exp_q.push_back(e);
        end
      end
    end
    cmd_seq++;
    s_cmd_commit = c;
    s_cmd_memset = m;
    s_cmd_size   = exp_size;
    s_cmd_valid  = 1'b1;
    @(negedge clk);
    s_cmd_valid  = 1'b0;
    check("busy_after_accept", 64'(busy), 64'(1));
  endtask

  // Returns cycles from accept edge to the done cycle (1 = cycle after accept).
  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 4000) begin
      @(negedge clk);
      lat++;
    end
    check("done_seen", 64'(done), 64'(1));
    @(negedge clk);
    check("ready_after_done", 64'(s_cmd_ready), 64'(1));
    check("idle_after_done", 64'({busy, done}), 64'(0));
  endtask

  task automatic check_reset_values();
    check("rst_ready", 64'(s_cmd_ready), 64'(1));
    check("rst_apply_flags", 64'({hApply, hCmdCommit, hCmdMemset}), 64'(0));
    check("rst_size", 64'(hCmdSize), 64'(0));
    check("rst_busy_done", 64'({busy, done}), 64'(0));
    check("rst_stream", 64'({m_axis_tvalid, m_axis_tlast, s_axis_tready}), 64'(0));
  endtask

  initial begin
    int lat;
    int w;
    logic [NT-1:0] rc, rm;
    reset        = 1'b1;
    hres         = 1'b1;
    s_cmd_valid  = 1'b0;
    s_cmd_commit = '0;
    s_cmd_memset = '0;
    s_cmd_size   = '0;
    cmd_id       = 0;
    cmd_seq      = 0;
    max_delay    = 0;
    rdy_mode     = 0;
    exp_commit   = '0;
    exp_memset   = '0;
    exp_size     = '0;
    last_commit  = -1;
    for (int i = 0; i < NT; i++) nb[i] = 1;
    repeat (3) @(negedge clk);
    check_reset_values();
    reset = 1'b0;
    hres  = 1'b0;

    // Memset-only, immediate handlers: minimum latency, done in cycle 4.
    issue_cmd(3'b000, 3'b101, 1, 1);
    wait_done(lat);
    check("memset_min_latency", 64'(lat), 64'(4));

    // Memset-only with slow handlers.
    max_delay = 10;
    issue_cmd(3'b000, 3'b101, 1, 1);
    wait_done(lat);

    // Empty command goes straight to done.
    issue_cmd(3'b000, 3'b000, 1, 1);
    wait_done(lat);
    check("empty_latency", 64'(lat), 64'(1));

    // Serialized commits, 4 beats each.
    max_delay = 3;
    issue_cmd(3'b011, 3'b000, 4, 4);
    wait_done(lat);

    // Commit plus memset on target 0, memset-only on target 2.
    issue_cmd(3'b001, 3'b101, 3, 3);
    wait_done(lat);

    // Backpressure toggling every cycle.
    rdy_mode = 1;
    issue_cmd(3'b111, 3'b010, 5, 5);
    wait_done(lat);

    // All three committed: tlast per target or merged into one packet.
    rdy_mode = 0;
    issue_cmd(3'b111, 3'b000, 3, 3);
    wait_done(lat);

    // Randomized commands.
    for (int k = 0; k < 40; k++) begin
      rdy_mode  = $urandom_range(2, 0);
      max_delay = $urandom_range(6, 0);
      rc        = NT'($urandom);
      rm        = NT'($urandom);
      issue_cmd(rc, rm, 1, 5);
      wait_done(lat);
    end

    // Reset during a commit stream.
    rdy_mode = 0;
    issue_cmd(3'b111, 3'b000, 8, 8);
    w = 0;
    while (!m_axis_tvalid && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("reached_stream_before_reset", 64'(m_axis_tvalid), 64'(1));
    reset = 1'b1;
    hres  = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values();
    exp_q.delete();
    reset = 1'b0;
    hres  = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 64'({s_cmd_ready, busy}), 64'(2'b10));

    // Recovery after reset.
    issue_cmd(3'b101, 3'b010, 2, 4);
    wait_done(lat);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
